// File: rtl/button_pulser.sv
// button_pulser: per-channel push-button conditioner.
// Each channel is synchronised, debounced against a shared slow sample tick,
// and turned into a clean level, a one-cycle press pulse and a press toggle.
module button_pulser #(
    parameter int unsigned N            = 5,
    parameter int unsigned TICK_DIV     = 131072,
    parameter int unsigned STABLE_TICKS = 3
) (
    input  logic         clk,
    input  logic         arst_i,
    input  logic [N-1:0] btn_i,
    input  logic [N-1:0] toggle_clr_i,
    output logic [N-1:0] level_o,
    output logic [N-1:0] pulse_o,
    output logic [N-1:0] toggle_o,
    output logic         tick_o
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned STB_W = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_TICKS - 1);

    // Two-stage synchroniser; s2 is the channel's synchronised view of the button.
    logic [N-1:0] s1;
    logic [N-1:0] s2;

    // Free-running sample-tick divider shared by all channels.
    logic [CNT_W-1:0] tick_cnt;

    // Per-channel count of consecutive ticks on which sync disagreed with level_o.
    logic [N-1:0][STB_W-1:0] stb_cnt;
    logic [N-1:0][STB_W-1:0] stb_cnt_nxt;
    logic [N-1:0]            level_nxt;

    // Synchronise the raw, asynchronous button inputs into the clk domain.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_i;
            s2 <= s1;
        end
    end

    // Divide clk down to the debounce sample rate, wrapping at TICK_DIV-1.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Tick strobe is decoded straight from the registered divider state.
    assign tick_o = (tick_cnt == TICK_LAST);

    // Next debounced level and stability count; only a tick can change either.
    always_comb begin
        level_nxt   = level_o;
        stb_cnt_nxt = stb_cnt;
        for (int unsigned i = 0; i < N; i++) begin
            if (tick_o) begin
                if (s2[i] == level_o[i]) begin
                    stb_cnt_nxt[i] = '0;
                end else if (stb_cnt[i] == STB_LAST) begin
                    level_nxt[i]   = s2[i];
                    stb_cnt_nxt[i] = '0;
                end else begin
                    stb_cnt_nxt[i] = stb_cnt[i] + STB_W'(1);
                end
            end
        end
    end

    // Register level, count and press pulse; the pulse is formed from the next
    // level so that it lands in the same cycle the level first reads high.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            stb_cnt <= '0;
            level_o <= '0;
            pulse_o <= '0;
        end else begin
            stb_cnt <= stb_cnt_nxt;
            level_o <= level_nxt;
            pulse_o <= level_nxt & ~level_o;
        end
    end

    // Flip the toggle on each press pulse; a clear wins over a coincident pulse.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            toggle_o <= '0;
        end else begin
            toggle_o <= (toggle_o ^ pulse_o) & ~toggle_clr_i;
        end
    end

endmodule

// File: tb/tb_button_pulser.sv
// Self-checking bench for button_pulser: directed scenarios plus random button
// activity, every cycle compared against a sample-history reference model.
module tb_button_pulser;

    localparam int unsigned N  = 2;
    localparam int unsigned TD = 4;
    localparam int unsigned ST = 3;

    logic         clk = 1'b0;
    logic         arst = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] clr = '0;
    logic [N-1:0] level_o;
    logic [N-1:0] pulse_o;
    logic [N-1:0] toggle_o;
    logic         tick_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    bit [N-1:0]  m_s1, m_s2, m_level, m_pulse, m_toggle;
    int unsigned m_cnt;
    bit          hist [N][$];

    int pcnt [N];

    button_pulser #(
        .N(N),
        .TICK_DIV(TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk(clk),
        .arst_i(arst),
        .btn_i(btn),
        .toggle_clr_i(clr),
        .level_o(level_o),
        .pulse_o(pulse_o),
        .toggle_o(toggle_o),
        .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0; m_toggle = '0;
        m_cnt = 0;
        for (int ch = 0; ch < N; ch++) hist[ch].delete();
    endtask

    // Level follows sync once the last ST tick samples since the previous
    // level change all disagree with the current level.
    task automatic model_step();
        bit [N-1:0] lvl_new;
        bit         all_diff;
        if (arst) begin
            model_reset();
            return;
        end
        lvl_new = m_level;
        if (m_cnt == TD - 1) begin
            for (int ch = 0; ch < N; ch++) begin
                hist[ch].push_back(m_s2[ch]);
                if (hist[ch].size() > ST) void'(hist[ch].pop_front());
                if (hist[ch].size() == ST) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < hist[ch].size(); k++)
                        if (hist[ch][k] == m_level[ch]) all_diff = 1'b0;
                    if (all_diff) begin
                        lvl_new[ch] = ~m_level[ch];
                        hist[ch].delete();
                    end
                end
            end
        end
        for (int ch = 0; ch < N; ch++) begin
            if (clr[ch]) m_toggle[ch] = 1'b0;
            else if (m_pulse[ch]) m_toggle[ch] = ~m_toggle[ch];
        end
        m_pulse = lvl_new & ~m_level;
        m_level = lvl_new;
        m_s2    = m_s1;
        m_s1    = btn;
        m_cnt   = (m_cnt + 1) % TD;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("level", level_o, m_level);
        check("pulse", pulse_o, m_pulse);
        check("toggle", toggle_o, m_toggle);
        check("tick", tick_o, (m_cnt == TD - 1) ? 1 : 0);
        for (int ch = 0; ch < N; ch++) if (pulse_o[ch]) pcnt[ch]++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_pcnt();
        for (int ch = 0; ch < N; ch++) pcnt[ch] = 0;
    endtask

    // Drive btn[0] to val and measure edges until level_o[0] follows.
    task automatic edge_latency(input bit val, input int budget, output int lat);
        lat = -1;
        btn[0] = val;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (lat < 0 && level_o[0] == val) begin
                lat = i + 1;
                if (val) check("pulse_with_rise", pulse_o[0], 1);
            end
        end
    endtask

    initial begin
        int lat;
        int hi_cycles;
        int both_cycles;
        int other_cycles;
        int ticks;
        model_reset();
        clear_pcnt();

        // Reset state.
        #2 arst = 1'b1;
        #1;
        check("rst_level", level_o, 0);
        check("rst_pulse", pulse_o, 0);
        check("rst_toggle", toggle_o, 0);
        check("rst_tick", tick_o, 0);
        @(negedge clk);
        arst = 1'b0;
        run(6);

        // Clean press on channel 0.
        clear_pcnt();
        edge_latency(1'b1, 40, lat);
        check("press_lat", (lat >= 11 && lat <= 14) ? 1 : 0, 1);
        check("press_pulses0", pcnt[0], 1);
        check("press_pulses1", pcnt[1], 0);
        check("press_toggle", toggle_o[0], 1);
        check("press_ch1_level", level_o[1], 0);

        // Release, then a second press flips the toggle back.
        clear_pcnt();
        edge_latency(1'b0, 30, lat);
        check("release_lat", (lat >= 11 && lat <= 14) ? 1 : 0, 1);
        check("release_pulses", pcnt[0], 0);
        check("release_toggle", toggle_o[0], 1);
        edge_latency(1'b1, 40, lat);
        check("repress_toggle", toggle_o[0], 0);
        edge_latency(1'b0, 30, lat);

        // Bounce: flip every 5 cycles, never stable long enough.
        clear_pcnt();
        hi_cycles = 0;
        for (int j = 0; j < 12; j++) begin
            btn[0] = ~btn[0];
            for (int i = 0; i < 5; i++) begin
                cycle();
                if (level_o[0]) hi_cycles++;
            end
        end
        btn[0] = 1'b0;
        run(20);
        check("bounce_level", hi_cycles, 0);
        check("bounce_pulses", pcnt[0], 0);
        check("bounce_toggle", toggle_o[0], 0);

        // Simultaneous presses on both channels.
        both_cycles = 0;
        other_cycles = 0;
        btn = '1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (pulse_o == '1) both_cycles++;
            else if (pulse_o != '0) other_cycles++;
        end
        check("simul_both", both_cycles, 1);
        check("simul_other", other_cycles, 0);
        btn = '0;
        run(30);

        // Clear held across the pulse wins, next plain press sets the toggle.
        clr[0] = 1'b1;
        btn[0] = 1'b1;
        run(40);
        check("clr_priority", toggle_o[0], 0);
        clr[0] = 1'b0;
        btn[0] = 1'b0;
        run(30);
        btn[0] = 1'b1;
        run(40);
        check("clr_then_press", toggle_o[0], 1);
        btn[0] = 1'b0;
        run(30);

        // Reset after two ticks of a held press.
        btn[0] = 1'b1;
        ticks = 0;
        for (int i = 0; i < 20 && ticks < 2; i++) begin
            cycle();
            if (tick_o) ticks++;
        end
        check("pre_reset_ticks", ticks, 2);
        arst = 1'b1;
        model_reset();
        #1;
        check("midrst_level", level_o, 0);
        check("midrst_pulse", pulse_o, 0);
        check("midrst_toggle", toggle_o, 0);
        check("midrst_tick", tick_o, 0);
        @(negedge clk);
        run(2);
        arst = 1'b0;
        clear_pcnt();
        lat = -1;
        ticks = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (ticks < 0 && tick_o) ticks = i + 1;
            if (lat < 0 && level_o[0]) lat = i + 1;
        end
        check("post_rst_first_tick", ticks, 3);
        check("post_rst_lat", (lat >= 11 && lat <= 14) ? 1 : 0, 1);
        check("post_rst_pulses", pcnt[0], 1);

        // Random activity with occasional clears and resets.
        btn = '0;
        for (int seg = 0; seg < 80; seg++) begin
            btn = N'($urandom_range(0, (1 << N) - 1));
            clr = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            if ($urandom_range(0, 39) == 0) begin
                arst = 1'b1;
                model_reset();
                @(negedge clk);
                run($urandom_range(1, 3));
                arst = 1'b0;
            end
            run($urandom_range(1, 20));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_pulser.md
# button_pulser

Multi-channel button conditioner between the raw board push-buttons and the game and display logic of the Stacker top level. For each channel it synchronises the raw input, debounces it on a slow sample tick, and produces:
- a clean level;
- a single-`clk` press pulse that drives the Stacker drop inputs;
- a press-toggled flag that drives pause and high-score display.

It replaces the ad-hoc shift-register edge detectors in the top level with one uniform, resettable block.

## Interface
Parameters:
- `N`, 5, number of button channels.
- `TICK_DIV`, 131072, `clk` cycles per debounce sample tick (≈1.31 ms at 100 MHz); must be ≥ 2.
- `STABLE_TICKS`, 3, consecutive ticks an input must differ from `level_o` before `level_o` follows it; must be ≥ 1.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `arst_i` in 1: reset, asynchronous, active-high; clock `clk`.
- `btn_i` in N: raw asynchronous button inputs, active-high.
- `toggle_clr_i` in N: synchronous per-channel clear of `toggle_o`.
- `level_o` out N: debounced button level.
- `pulse_o` out N: one-cycle press pulse.
- `toggle_o` out N: flips on each press pulse.
- `tick_o` out 1: debounce sample strobe, one `clk` cycle wide.

## Operation
- **Synchroniser:** 2-FF per channel (`s1`, `s2`), reset 0. `sync = s2`.
- **Tick counter:**
  - Width `clog2(TICK_DIV)`, reset 0, increments every cycle, wraps from `TICK_DIV-1` to 0.
  - `tick_o` = 1 exactly while the counter equals `TICK_DIV-1`, decoded from the registered counter.
- **Stability counter:** one per channel, width `clog2(STABLE_TICKS+1)`, reset 0. On a cycle with `tick_o` = 1:
  - `sync == level_o` → counter = 0.
  - `sync != level_o` and counter+1 < `STABLE_TICKS` → counter += 1.
  - `sync != level_o` and counter+1 == `STABLE_TICKS` → `level_o` <= `sync`, counter = 0.
  - Non-tick cycles leave the counter and `level_o` unchanged.
  - A bounce back to the current level on any tick restarts the count. The counter never exceeds `STABLE_TICKS-1`.
- **Pulse:** `pulse_o[i]` is registered. It is 1 for exactly one cycle: the first cycle in which `level_o[i]` reads 1 after reading 0. A release (1→0) never pulses. Pulses need at least `STABLE_TICKS` ticks of separation by construction.
- **Toggle:** `toggle_o[i]` is registered, reset 0.
  - `toggle_clr_i[i]` = 1 → 0. Clear has priority over a coincident pulse.
  - Else `pulse_o[i]` = 1 → inverted. The flip is visible the cycle after the pulse.
- **Channel independence:** channels are fully independent. Simultaneous presses on several channels yield pulses in the same cycle.

## Timing
- **Reset values:** all outputs 0 while `arst_i` is high. All counters and synchroniser flops are 0.
- **Reset release:** the counter starts from 0, so the first `tick_o` is in cycle `TICK_DIV-1` after the first post-reset edge.
- **Reset mid-debounce:** discards progress. A button held through reset release is seen as a new press: `level_o` rises and one pulse is emitted after the normal debounce latency.
- **Input to `sync` latency:** 2 `clk` edges.
- **`sync` change to `level_o` change:** between `(STABLE_TICKS-1)*TICK_DIV+1` and `STABLE_TICKS*TICK_DIV` cycles, depending on tick phase. The input must remain changed at every one of those `STABLE_TICKS` ticks.
- **`level_o` rise to `pulse_o`:** 0 cycles; they coincide in the same cycle.
- **`pulse_o` to `toggle_o` flip:** 1 cycle.
- **`tick_o` duty:** 1 cycle in `TICK_DIV`, never two consecutive cycles.

## Test plan
All scenarios use `N`=2, `TICK_DIV`=4, `STABLE_TICKS`=3.

1. **Clean press:** raise `btn_i[0]` and hold 40 cycles → `level_o[0]` rises 11–14 cycles after the input edge. `pulse_o[0]` is high for exactly 1 cycle, coincident with that rise. `toggle_o[0]` goes 0→1 the next cycle. Channel 1 outputs stay 0.
2. **Bounce rejection:** toggle `btn_i[0]` every 5 cycles for 60 cycles → `level_o[0]`, `pulse_o[0]` and `toggle_o[0]` remain 0 throughout. The stability counter never reaches 3.
3. **Release:** from a held, debounced state, drop `btn_i[0]` → `level_o[0]` falls within 11–14 cycles, `pulse_o[0]` stays 0 and `toggle_o[0]` is unchanged. A second full press then flips `toggle_o[0]` back to 0.
4. **Simultaneous channels:** raise both bits of `btn_i` in the same cycle → both `pulse_o` bits are high in the same single cycle.
5. **Clear priority:** hold `toggle_clr_i[0]`=1 across the pulse cycle of a press → `toggle_o[0]` = 0 afterwards. With `toggle_clr_i` = 0 on the next press, `toggle_o[0]` becomes 1.
6. **Reset mid-debounce:** assert `arst_i` after 2 ticks of a held press, release it 3 cycles later, keep the button held → all outputs read 0 during reset. Exactly one pulse follows 11–14 cycles after release, and `tick_o` first fires 3 cycles after release.
